// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and the PLL/core-reset fabric it controls.
interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       core_reset_n;
    logic       lock_lost;
    logic [7:0] retry_count;
    logic [1:0] state;

    modport master (
        input  pll_locked,
        output pll_rst,
        output core_reset_n,
        output lock_lost,
        output retry_count,
        output state
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  core_reset_n,
        input  lock_lost,
        input  retry_count,
        input  state
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Pulses the PLL reset, waits for a stable lock, then releases the core reset.
// Optional lock-timeout retry watchdog is enabled by defining PLL_SUP_WATCHDOG_EN.
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
    input logic                   refclk,
    input logic                   reset_n,
    pll_lock_supervisor_if.master sup_if
);

    if (RST_PULSE_CYCLES < 1 || RST_PULSE_CYCLES > 65535) begin : g_bad_rst_pulse
        $error("RST_PULSE_CYCLES out of range 1..65535");
    end
    if (LOCK_STABLE_CYCLES < 1 || LOCK_STABLE_CYCLES > (1 << 20)) begin : g_bad_stable
        $error("LOCK_STABLE_CYCLES out of range 1..2^20");
    end
    if (LOCK_TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("LOCK_TIMEOUT_CYCLES must be at least 1");
    end

    localparam int unsigned CntMaxBase = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                         RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
`ifdef PLL_SUP_WATCHDOG_EN
    localparam int unsigned CntMax = (CntMaxBase > LOCK_TIMEOUT_CYCLES) ?
                                     CntMaxBase : LOCK_TIMEOUT_CYCLES;
`else
    localparam int unsigned CntMax = CntMaxBase;
`endif
    localparam int unsigned CntW = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] RstLast    = CntW'(RST_PULSE_CYCLES - 1);
    localparam logic [CntW-1:0] StableLast = CntW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] CntTop     = CntW'(CntMax);
`ifdef PLL_SUP_WATCHDOG_EN
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        StResetPll = 2'd0,
        StWaitLock = 2'd1,
        StStable   = 2'd2,
        StRun      = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic [1:0]      sync_q, sync_d;
    logic            lock_s;
    logic            pll_rst_q, pll_rst_d;
    logic            core_reset_n_q, core_reset_n_d;
    logic            lock_lost_q, lock_lost_d;
`ifdef PLL_SUP_WATCHDOG_EN
    logic [7:0]      retry_q, retry_d;
`endif

    // pll_locked is asynchronous to refclk; only sync_q[1] is ever used for decisions.
    assign sync_d = {sync_q[0], sup_if.pll_locked};
    assign lock_s = sync_q[1];

    // Saturating increment: the counter never wraps even if a parameter is mis-set.
    assign cnt_inc = (cnt_q == CntTop) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_lost_d = 1'b0;
`ifdef PLL_SUP_WATCHDOG_EN
        retry_d     = retry_q;
`endif

        unique case (state_q)
            StResetPll: begin
                if (cnt_q == RstLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StWaitLock: begin
                if (lock_s) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end else begin
`ifdef PLL_SUP_WATCHDOG_EN
                    if (cnt_q == TimeoutLast) begin
                        state_d = StResetPll;
                        cnt_d   = '0;
                        retry_d = (retry_q == 8'hff) ? retry_q : retry_q + 8'd1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            StStable: begin
                // Loss of lock takes priority over a count completing on the same cycle.
                if (!lock_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StRun: begin
                if (!lock_s) begin
                    state_d     = StResetPll;
                    cnt_d       = '0;
                    lock_lost_d = 1'b1;
                end
            end
            default: begin
                state_d = StResetPll;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        pll_rst_d      = (state_d == StResetPll);
        core_reset_n_d = (state_d == StRun);
    end

    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StResetPll;
            cnt_q          <= '0;
            sync_q         <= 2'b00;
            pll_rst_q      <= 1'b1;
            core_reset_n_q <= 1'b0;
            lock_lost_q    <= 1'b0;
`ifdef PLL_SUP_WATCHDOG_EN
            retry_q        <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sync_q         <= sync_d;
            pll_rst_q      <= pll_rst_d;
            core_reset_n_q <= core_reset_n_d;
            lock_lost_q    <= lock_lost_d;
`ifdef PLL_SUP_WATCHDOG_EN
            retry_q        <= retry_d;
`endif
        end
    end

    assign sup_if.pll_rst      = pll_rst_q;
    assign sup_if.core_reset_n = core_reset_n_q;
    assign sup_if.lock_lost    = lock_lost_q;
    assign sup_if.state        = state_q;
`ifdef PLL_SUP_WATCHDOG_EN
    assign sup_if.retry_count  = retry_q;
`else
    assign sup_if.retry_count  = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus randomized lock
// traffic compared against a behavioural model. Honors PLL_SUP_WATCHDOG_EN when defined.
module tb_pll_lock_supervisor;

    localparam int RstCycles     = 4;
    localparam int StableCycles  = 8;
    localparam int TimeoutCycles = 32;

    logic refclk  = 1'b0;
    logic reset_n = 1'b0;

    pll_lock_supervisor_if sup_if ();

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (RstCycles),
        .LOCK_STABLE_CYCLES (StableCycles),
        .LOCK_TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .refclk (refclk),
        .reset_n(reset_n),
        .sup_if (sup_if)
    );

    always #5 refclk = ~refclk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: phase numbers follow the spec's state encoding; elapsed counts
    // completed cycles in the current phase; lock decisions see pll_locked two edges late.
    int m_phase;
    int m_elapsed;
    int m_retries;
    bit m_lost;
    bit m_hist[2];

    function automatic void model_reset();
        m_phase   = 0;
        m_elapsed = 0;
        m_retries = 0;
        m_lost    = 1'b0;
        m_hist[0] = 1'b0;
        m_hist[1] = 1'b0;
    endfunction

    function automatic void model_edge();
        bit lk;
        if (reset_n !== 1'b1) begin
            model_reset();
            return;
        end
        lk        = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = (sup_if.pll_locked === 1'b1);
        m_lost    = 1'b0;
        case (m_phase)
            0: begin
                m_elapsed++;
                if (m_elapsed == RstCycles) begin
                    m_phase   = 1;
                    m_elapsed = 0;
                end
            end
            1: begin
                if (lk) begin
                    m_phase   = 2;
                    m_elapsed = 0;
                end else begin
`ifdef PLL_SUP_WATCHDOG_EN
                    m_elapsed++;
                    if (m_elapsed == TimeoutCycles) begin
                        m_phase   = 0;
                        m_elapsed = 0;
                        if (m_retries < 255) m_retries++;
                    end
`endif
                end
            end
            2: begin
                if (!lk) begin
                    m_phase   = 1;
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == StableCycles) begin
                        m_phase   = 3;
                        m_elapsed = 0;
                    end
                end
            end
            default: begin
                if (!lk) begin
                    m_phase   = 0;
                    m_elapsed = 0;
                    m_lost    = 1'b1;
                end
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge refclk);
        model_edge();
        #1;
    endtask

    task automatic do_reset(input logic locked);
        reset_n           = 1'b0;
        sup_if.pll_locked = locked;
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        sup_if.pll_locked = 1'b0;
        reset_n           = 1'b0;
        repeat (2) tick();
        total++;
        if (sup_if.pll_rst !== 1'b1) begin
            bad++;
            $display("FAIL reset_pll_rst: got %b want 1", sup_if.pll_rst);
        end
        total++;
        if (sup_if.core_reset_n !== 1'b0) begin
            bad++;
            $display("FAIL reset_core_reset_n: got %b want 0", sup_if.core_reset_n);
        end
        total++;
        if (sup_if.lock_lost !== 1'b0) begin
            bad++;
            $display("FAIL reset_lock_lost: got %b want 0", sup_if.lock_lost);
        end
        total++;
        if (sup_if.retry_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_retry_count: got %0d want 0", sup_if.retry_count);
        end
        total++;
        if (sup_if.state !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: got %0d want 0", sup_if.state);
        end
    endtask

    task automatic test_clean_lock();
        int rst_hi    = 0;
        int stable_n  = 0;
        int guard     = 0;
        bit lost_seen = 1'b0;
        do_reset(1'b1);
        while (sup_if.pll_rst === 1'b1 && guard < 50) begin
            rst_hi++;
            lost_seen = lost_seen | (sup_if.lock_lost === 1'b1);
            tick();
            guard++;
        end
        total++;
        if (rst_hi != RstCycles) begin
            bad++;
            $display("FAIL clean_rst_pulse: got %0d cycles want %0d", rst_hi, RstCycles);
        end
        total++;
        if (sup_if.state !== 2'd1) begin
            bad++;
            $display("FAIL clean_wait_state: got %0d want 1", sup_if.state);
        end
        tick();
        guard = 0;
        while (sup_if.state === 2'd2 && guard < 50) begin
            stable_n++;
            lost_seen = lost_seen | (sup_if.lock_lost === 1'b1) | (sup_if.core_reset_n === 1'b1);
            tick();
            guard++;
        end
        total++;
        if (stable_n != StableCycles) begin
            bad++;
            $display("FAIL clean_stable_len: got %0d cycles want %0d", stable_n, StableCycles);
        end
        total++;
        if ({sup_if.core_reset_n, sup_if.state} !== 3'b1_11) begin
            bad++;
            $display("FAIL clean_run: got core=%b state=%0d want core=1 state=3",
                     sup_if.core_reset_n, sup_if.state);
        end
        total++;
        if (lost_seen !== 1'b0) begin
            bad++;
            $display("FAIL clean_no_lost: got lost/early-release=%b want 0", lost_seen);
        end
    endtask

    task automatic test_run_lock_loss();
        int rst_hi = 0;
        int lost_n = 0;
        int guard  = 0;
        sup_if.pll_locked = 1'b0;
        tick();
        sup_if.pll_locked = 1'b1;
        total++;
        if (sup_if.core_reset_n !== 1'b1) begin
            bad++;
            $display("FAIL loss_hold1: got core=%b want 1", sup_if.core_reset_n);
        end
        tick();
        total++;
        if ({sup_if.core_reset_n, sup_if.lock_lost} !== 2'b10) begin
            bad++;
            $display("FAIL loss_hold2: got core,lost=%b want 10",
                     {sup_if.core_reset_n, sup_if.lock_lost});
        end
        tick();
        total++;
        if ({sup_if.core_reset_n, sup_if.lock_lost, sup_if.pll_rst, sup_if.state} !== 5'b0_1_1_00) begin
            bad++;
            $display("FAIL loss_response: got core,lost,rst,state=%b want 01100",
                     {sup_if.core_reset_n, sup_if.lock_lost, sup_if.pll_rst, sup_if.state});
        end
        while (sup_if.pll_rst === 1'b1 && guard < 50) begin
            rst_hi++;
            if (sup_if.lock_lost === 1'b1) lost_n++;
            tick();
            guard++;
        end
        total++;
        if (rst_hi != RstCycles) begin
            bad++;
            $display("FAIL loss_rst_pulse: got %0d cycles want %0d", rst_hi, RstCycles);
        end
        total++;
        if (lost_n != 1) begin
            bad++;
            $display("FAIL loss_pulse_width: got %0d cycles want 1", lost_n);
        end
        guard = 0;
        while (sup_if.core_reset_n !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        total++;
        if (sup_if.core_reset_n !== 1'b1) begin
            bad++;
            $display("FAIL loss_rerelease: got core=%b want 1", sup_if.core_reset_n);
        end
    endtask

    task automatic test_stable_dropout();
        int guard    = 0;
        int stable_n = 0;
        bit leak     = 1'b0;
        do_reset(1'b1);
        while (sup_if.state !== 2'd2 && guard < 40) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        sup_if.pll_locked = 1'b0;
        tick();
        sup_if.pll_locked = 1'b1;
        leak = leak | (sup_if.lock_lost === 1'b1) | (sup_if.core_reset_n === 1'b1);
        tick();
        leak = leak | (sup_if.lock_lost === 1'b1) | (sup_if.core_reset_n === 1'b1);
        tick();
        total++;
        if (sup_if.state !== 2'd1) begin
            bad++;
            $display("FAIL drop_to_wait: got state=%0d want 1", sup_if.state);
        end
        leak = leak | (sup_if.lock_lost === 1'b1) | (sup_if.core_reset_n === 1'b1);
        tick();
        guard = 0;
        while (sup_if.state === 2'd2 && guard < 50) begin
            stable_n++;
            leak = leak | (sup_if.lock_lost === 1'b1) | (sup_if.core_reset_n === 1'b1);
            tick();
            guard++;
        end
        total++;
        if (stable_n != StableCycles) begin
            bad++;
            $display("FAIL drop_recount: got %0d cycles want %0d", stable_n, StableCycles);
        end
        total++;
        if (leak !== 1'b0) begin
            bad++;
            $display("FAIL drop_no_lost: got lost/release during dropout=%b want 0", leak);
        end
        total++;
        if (sup_if.state !== 2'd3) begin
            bad++;
            $display("FAIL drop_run: got state=%0d want 3", sup_if.state);
        end
    endtask

    task automatic test_stable_boundary();
        int guard = 0;
        do_reset(1'b1);
        while (sup_if.state !== 2'd2 && guard < 40) begin
            tick();
            guard++;
        end
        repeat (5) tick();
        sup_if.pll_locked = 1'b0;
        tick();
        sup_if.pll_locked = 1'b1;
        tick();
        total++;
        if (sup_if.state !== 2'd2) begin
            bad++;
            $display("FAIL boundary_last_stable: got state=%0d want 2", sup_if.state);
        end
        tick();
        total++;
        if ({sup_if.state, sup_if.core_reset_n} !== 3'b01_0) begin
            bad++;
            $display("FAIL boundary_loss_wins: got state=%0d core=%b want state=1 core=0",
                     sup_if.state, sup_if.core_reset_n);
        end
    endtask

    task automatic test_async_reset();
        int guard  = 0;
        int rst_hi = 0;
        do_reset(1'b1);
        while (sup_if.state !== 2'd2 && guard < 40) begin
            tick();
            guard++;
        end
        repeat (2) tick();
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({sup_if.pll_rst, sup_if.core_reset_n, sup_if.state} !== 4'b1_0_00) begin
            bad++;
            $display("FAIL async_stable: got rst,core,state=%b want 1000",
                     {sup_if.pll_rst, sup_if.core_reset_n, sup_if.state});
        end
        tick();
        reset_n = 1'b1;
        guard   = 0;
        while (sup_if.pll_rst === 1'b1 && guard < 50) begin
            rst_hi++;
            tick();
            guard++;
        end
        total++;
        if (rst_hi != RstCycles) begin
            bad++;
            $display("FAIL async_rst_pulse: got %0d cycles want %0d", rst_hi, RstCycles);
        end
        guard = 0;
        while (sup_if.core_reset_n !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({sup_if.pll_rst, sup_if.core_reset_n} !== 2'b10) begin
            bad++;
            $display("FAIL async_run: got rst,core=%b want 10",
                     {sup_if.pll_rst, sup_if.core_reset_n});
        end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_wait_lock();
`ifdef PLL_SUP_WATCHDOG_EN
        int   rises     = 0;
        int   last_rise = -1;
        int   cyc       = 0;
        int   width     = 0;
        int   exp_retry;
        logic prev_rst;
        do_reset(1'b0);
        prev_rst = sup_if.pll_rst;
        while (rises < 300 && cyc < 300 * (RstCycles + TimeoutCycles) + 400) begin
            tick();
            cyc++;
            if (sup_if.pll_rst === 1'b1 && prev_rst === 1'b0) begin
                rises++;
                width = 0;
                if (last_rise >= 0) begin
                    total++;
                    if (cyc - last_rise != RstCycles + TimeoutCycles) begin
                        bad++;
                        $display("FAIL wd_period: got %0d cycles want %0d", cyc - last_rise,
                                 RstCycles + TimeoutCycles);
                    end
                end
                last_rise = cyc;
                exp_retry = (rises > 255) ? 255 : rises;
                total++;
                if (sup_if.retry_count !== 8'(exp_retry)) begin
                    bad++;
                    $display("FAIL wd_retry: got %0d want %0d", sup_if.retry_count, exp_retry);
                end
            end
            if (sup_if.pll_rst === 1'b1) width++;
            if (sup_if.pll_rst === 1'b0 && prev_rst === 1'b1 && rises >= 1) begin
                total++;
                if (width != RstCycles) begin
                    bad++;
                    $display("FAIL wd_pulse_width: got %0d cycles want %0d", width, RstCycles);
                end
            end
            prev_rst = sup_if.pll_rst;
        end
        total++;
        if (rises != 300) begin
            bad++;
            $display("FAIL wd_retry_events: got %0d want 300", rises);
        end
        total++;
        if (sup_if.retry_count !== 8'd255) begin
            bad++;
            $display("FAIL wd_saturate: got %0d want 255", sup_if.retry_count);
        end
`else
        int bad_cycles = 0;
        do_reset(1'b0);
        repeat (RstCycles) tick();
        for (int i = 0; i < 1000; i++) begin
            if (sup_if.state !== 2'd1 || sup_if.pll_rst !== 1'b0 || sup_if.retry_count !== 8'd0)
                bad_cycles++;
            tick();
        end
        total++;
        if (bad_cycles != 0) begin
            bad++;
            $display("FAIL nowd_wait_forever: got %0d off-nominal cycles want 0", bad_cycles);
        end
        total++;
        if ({sup_if.state, sup_if.pll_rst, sup_if.retry_count} !== {2'd1, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL nowd_final: got state=%0d rst=%b retry=%0d want 1 0 0",
                     sup_if.state, sup_if.pll_rst, sup_if.retry_count);
        end
`endif
    endtask

    task automatic test_random();
        int          run_left = 0;
        int          shown    = 0;
        logic [12:0] exp_v;
        logic [12:0] act_v;
        do_reset(1'($urandom_range(0, 1)));
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                sup_if.pll_locked = ~sup_if.pll_locked;
                if (sup_if.pll_locked === 1'b1) run_left = int'($urandom_range(1, 40));
                else if ($urandom_range(0, 9) == 0) run_left = int'($urandom_range(20, 80));
                else run_left = int'($urandom_range(1, 4));
            end
            run_left--;
            if ($urandom_range(0, 499) == 0) begin
                #2;
                reset_n = 1'b0;
                model_reset();
                #1;
            end
            tick();
            exp_v = {m_phase == 0, m_phase == 3, m_lost, 8'(m_retries), 2'(m_phase)};
            act_v = {sup_if.pll_rst, sup_if.core_reset_n, sup_if.lock_lost,
                     sup_if.retry_count, sup_if.state};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle%0d: got rst,core,lost,retry,state=%b want %b",
                             i, act_v, exp_v);
                end
            end
            if (reset_n !== 1'b1) reset_n = 1'b1;
        end
    endtask

    initial begin
        sup_if.pll_locked = 1'b0;
        model_reset();
        test_reset();
        test_clean_lock();
        test_run_lock_loss();
        test_stable_dropout();
        test_stable_boundary();
        test_async_reset();
        test_wait_lock();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout: got no completion want completion");
        $fatal(1, "simulation time limit");
    end

endmodule
